alu_issue: RTL and testbench

- Initiator side of the execute-stage ALU interface: accepts decoded ALU operations over a valid/ready handshake and buffers them in a FIFO.
- Drives the ALU's valid, command and operand inputs one operation per cycle.
- Captures the ALU's registered result exactly one cycle after issue and returns it, tagged, over a valid/ready writeback port.
- Sits between decode and writeback; instantiated beside alu.

---
 rtl/alu_issue.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_issue.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: buffers decoded ALU ops, issues one per cycle to a registered ALU and
// returns tagged results through a 2-entry output buffer. Define ALU_ISSUE_FWD_EN
// to enable result forwarding onto operand A/B.

package alu_issue_pkg;
  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3,
    ALU_XOR = 3'd4
  } alu_cmd_e;
endpackage

module alu_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_cmd,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_fwd_a,
  input  logic             in_fwd_b,
  output logic             alu_valid,
  output logic [2:0]       alu_command,
  output logic [31:0]      alu_in_a,
  output logic [31:0]      alu_in_b,
  input  logic [31:0]      alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]       cmd;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
`ifdef ALU_ISSUE_FWD_EN
    logic             fwd_a;
    logic             fwd_b;
`endif
  } op_t;

  typedef struct packed {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
  } res_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  op_t              fifo_mem_q [DEPTH];
  op_t              fifo_mem_d [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

  res_t             ob_mem_q [2];
  res_t             ob_mem_d [2];
  logic             ob_wr_q, ob_wr_d;
  logic             ob_rd_q, ob_rd_d;
  logic [1:0]       ob_cnt_q, ob_cnt_d;

  logic             inflight_q, inflight_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  op_t              in_op;
  op_t              head;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             issue;
  logic             ob_pop;
  logic [1:0]       occ;
  logic [31:0]      iss_a;
  logic [31:0]      iss_b;

  // ---------------------------------------------------------------------------
  // Input FIFO status and handshake
  // ---------------------------------------------------------------------------
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                      (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign head       = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

  assign in_op.cmd = in_cmd;
  assign in_op.a   = in_a;
  assign in_op.b   = in_b;
  assign in_op.tag = in_tag;
`ifdef ALU_ISSUE_FWD_EN
  assign in_op.fwd_a = in_fwd_a;
  assign in_op.fwd_b = in_fwd_b;
`else
  logic unused_fwd;
  assign unused_fwd = in_fwd_a | in_fwd_b;
`endif

  // ---------------------------------------------------------------------------
  // Issue: at most two ops may sit between the FIFO and the consumer
  // (one in the ALU pipeline plus the output buffer, net of this cycle's pop).
  // ---------------------------------------------------------------------------
  assign out_valid = (ob_cnt_q != 2'd0);
  assign ob_pop    = out_valid && out_ready;
  assign occ       = 2'(inflight_q) + ob_cnt_q - 2'(ob_pop);
  assign issue     = !fifo_empty && (occ < 2'd2);

`ifdef ALU_ISSUE_FWD_EN
  logic [31:0] last_result_q, last_result_d;
  logic [31:0] fwd_src;

  // The previous op's result is on alu_result while it is in flight,
  // otherwise it was kept in last_result.
  assign fwd_src = inflight_q ? alu_result : last_result_q;
  assign iss_a   = head.fwd_a ? fwd_src : head.a;
  assign iss_b   = head.fwd_b ? fwd_src : head.b;

  always_comb begin
    last_result_d = last_result_q;
    if (inflight_q) last_result_d = alu_result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_result_q <= '0;
    else        last_result_q <= last_result_d;
  end
`else
  assign iss_a = head.a;
  assign iss_b = head.b;
`endif

  assign alu_valid   = issue;
  assign alu_command = issue ? head.cmd : 3'd0;
  assign alu_in_a    = issue ? iss_a : 32'd0;
  assign alu_in_b    = issue ? iss_b : 32'd0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before any condition, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q[PTR_W-1:0]] = in_op;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (issue) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  always_comb begin
    inflight_d = issue;
    tag_d      = issue ? head.tag : tag_q;
  end

  always_comb begin
    ob_mem_d = ob_mem_q;
    ob_wr_d  = ob_wr_q;
    ob_rd_d  = ob_rd_q;
    ob_cnt_d = ob_cnt_q + 2'(inflight_q) - 2'(ob_pop);
    if (inflight_q) begin
      ob_mem_d[ob_wr_q].result = alu_result;
      ob_mem_d[ob_wr_q].tag    = tag_q;
      ob_wr_d = !ob_wr_q;
    end
    if (ob_pop) ob_rd_d = !ob_rd_q;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: control state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ob_wr_q    <= 1'b0;
      ob_rd_q    <= 1'b0;
      ob_cnt_q   <= 2'd0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ob_wr_q    <= ob_wr_d;
      ob_rd_q    <= ob_rd_d;
      ob_cnt_q   <= ob_cnt_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  // NOTE: storage arrays are not reset; pointers and counts define which
  // entries are valid, and all outputs derived from storage are gated.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
    ob_mem_q   <= ob_mem_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_result = out_valid ? ob_mem_q[ob_rd_q].result : 32'd0;
  assign out_tag    = out_valid ? ob_mem_q[ob_rd_q].tag : '0;
  assign busy       = !fifo_empty || inflight_q || out_valid;

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue with a registered ALU model attached.
// Checks latency, streaming, wrap-around, back-pressure, forwarding and reset.

module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_cmd;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        in_fwd_a;
  logic        in_fwd_b;
  logic        alu_valid;
  logic [2:0]  alu_command;
  logic [31:0] alu_in_a;
  logic [31:0] alu_in_b;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  tag;
    int          cyc;
  } res_rec_t;

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
  } iss_rec_t;

  res_rec_t rq[$];
  iss_rec_t iq[$];

  alu_issue #(.DEPTH(4), .TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .in_fwd_a(in_fwd_a), .in_fwd_b(in_fwd_b),
    .alu_valid(alu_valid), .alu_command(alu_command),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_model(input logic [2:0] c,
                                            input logic [31:0] a, b);
    case (c)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_XOR: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Registered ALU: result appears the cycle after alu_valid.
  initial alu_result = 32'd0;
  always @(posedge clk)
    if (alu_valid) alu_result <= alu_model(alu_command, alu_in_a, alu_in_b);

  always @(negedge clk) begin
    if (reset && out_valid && out_ready)
      rq.push_back('{result: out_result, tag: out_tag, cyc: cyc});
    if (reset && alu_valid) begin
      iq.push_back('{cmd: alu_command, a: alu_in_a, b: alu_in_b});
      pulses++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one op and hold it until accepted; returns one cycle after handshake.
  task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] t, input logic fa, input logic fb);
    int k = 0;
    in_valid = 1'b1; in_cmd = c; in_a = a; in_b = b; in_tag = t;
    in_fwd_a = fa; in_fwd_b = fb;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 50) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_fwd_a = 1'b0; in_fwd_b = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int k = 0;
    while (rq.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (rq.size() < n) check("wait_results", 64'(rq.size()), 64'(n));
  endtask

  task automatic drain();
    int k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_idle", 64'(busy), 64'd0);
    @(negedge clk);
    rq.delete();
    iq.delete();
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_cmd = 3'd0; in_a = 32'd0; in_b = 32'd0;
    in_tag = 5'd0; in_fwd_a = 1'b0; in_fwd_b = 1'b0; out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alu_valid", 64'(alu_valid), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_outputs", {alu_valid, alu_command, alu_in_a[7:0], alu_in_b[7:0],
                          out_valid, out_result[7:0], out_tag, busy}, 64'd0);
    check("rel_out_result", 64'(out_result), 64'd0);

    // Single op latency
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_alu_valid_c1", 64'(alu_valid), 64'd1);
    check("t1_alu_cmd", 64'(alu_command), 64'(ALU_ADD));
    check("t1_alu_in_a", 64'(alu_in_a), 64'd5);
    check("t1_alu_in_b", 64'(alu_in_b), 64'd7);
    @(negedge clk);
    check("t1_out_valid_c2", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("t1_out_valid_c3", 64'(out_valid), 64'd1);
    check("t1_out_result", 64'(out_result), 64'd12);
    check("t1_out_tag", 64'(out_tag), 64'd3);
    drain();
    check("idle_cmd", 64'(alu_command), 64'd0);
    check("idle_a", 64'(alu_in_a), 64'd0);
    check("idle_b", 64'(alu_in_b), 64'd0);

    // Back-to-back stream
    @(posedge clk); #1;
    send(ALU_SUB, 32'd10, 32'd3, 5'd1, 1'b0, 1'b0);
    send(ALU_XOR, 32'hFF, 32'h0F, 5'd2, 1'b0, 1'b0);
    send(ALU_AND, 32'hF0, 32'h3C, 5'd4, 1'b0, 1'b0);
    wait_results(3);
    check("t2_res0", 64'(rq[0].result), 64'd7);
    check("t2_tag0", 64'(rq[0].tag), 64'd1);
    check("t2_res1", 64'(rq[1].result), 64'hF0);
    check("t2_tag1", 64'(rq[1].tag), 64'd2);
    check("t2_res2", 64'(rq[2].result), 64'h30);
    check("t2_tag2", 64'(rq[2].tag), 64'd4);
    check("t2_gap01", 64'(rq[1].cyc - rq[0].cyc), 64'd1);
    check("t2_gap12", 64'(rq[2].cyc - rq[1].cyc), 64'd1);
    drain();

    // Wrap-around and unknown command pass-through
    @(posedge clk); #1;
    send(ALU_ADD, 32'hFFFF_FFFF, 32'd2, 5'd7, 1'b0, 1'b0);
    send(3'd7, 32'd1, 32'd2, 5'd8, 1'b0, 1'b0);
    wait_results(2);
    check("t3_wrap", 64'(rq[0].result), 64'd1);
    check("t3_unknown_cmd", 64'(iq[1].cmd), 64'd7);
    check("t3_unknown_tag", 64'(rq[1].tag), 64'd8);
    drain();

    // Back-pressure
    out_ready = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++)
      send(ALU_ADD, 32'(i), 32'd100, 5'(10 + i), 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("t4_pulses", 64'(pulses), 64'd2);
    check("t4_in_ready", 64'(in_ready), 64'd0);
    check("t4_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("t4_stall_result", 64'(out_result), 64'd100);
      check("t4_stall_tag", 64'(out_tag), 64'd10);
      check("t4_stall_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_results(6);
    for (int i = 0; i < 6; i++) begin
      check("t4_drain_result", 64'(rq[i].result), 64'(100 + i));
      check("t4_drain_tag", 64'(rq[i].tag), 64'(10 + i));
    end
    check("t4_total_pulses", 64'(pulses), 64'd6);
    drain();

    // Forwarding, back-to-back
    @(posedge clk); #1;
    send(ALU_ADD, 32'd2, 32'd3, 5'd5, 1'b0, 1'b0);
    send(ALU_ADD, 32'd1, 32'd10, 5'd6, 1'b1, 1'b0);
    send(ALU_ADD, 32'd1, 32'd2, 5'd7, 1'b1, 1'b1);
    wait_results(3);
    check("t5_res0", 64'(rq[0].result), 64'd5);
`ifdef ALU_ISSUE_FWD_EN
    check("t5_fwd_a1", 64'(iq[1].a), 64'd5);
    check("t5_res1", 64'(rq[1].result), 64'd15);
    check("t5_fwd_a2", 64'(iq[2].a), 64'd15);
    check("t5_fwd_b2", 64'(iq[2].b), 64'd15);
    check("t5_res2", 64'(rq[2].result), 64'd30);
`else
    check("t5_nofwd_a1", 64'(iq[1].a), 64'd1);
    check("t5_res1", 64'(rq[1].result), 64'd11);
    check("t5_nofwd_b2", 64'(iq[2].b), 64'd2);
    check("t5_res2", 64'(rq[2].result), 64'd3);
`endif
    drain();

    // Forwarding across idle cycles
    @(posedge clk); #1;
    send(ALU_SUB, 32'd9, 32'd4, 5'd9, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send(ALU_ADD, 32'd1, 32'd10, 5'd11, 1'b1, 1'b0);
    wait_results(2);
    check("t5g_res0", 64'(rq[0].result), 64'd5);
`ifdef ALU_ISSUE_FWD_EN
    check("t5g_fwd_a", 64'(iq[1].a), 64'd5);
    check("t5g_res1", 64'(rq[1].result), 64'd15);
`else
    check("t5g_nofwd_a", 64'(iq[1].a), 64'd1);
    check("t5g_res1", 64'(rq[1].result), 64'd11);
`endif
    drain();

    // Reset with ops queued and one in flight
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      send(ALU_ADD, 32'(i), 32'd200, 5'(20 + i), 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #1;
    check("t6_pre_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    check("t6_alu_valid", 64'(alu_valid), 64'd0);
    rq.delete();
    iq.delete();
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("t6_no_stale", 64'(rq.size()), 64'd0);
    check("t6_idle_busy", 64'(busy), 64'd0);

    // Forwarding with no prior op since reset
    @(posedge clk); #1;
    send(ALU_ADD, 32'd7, 32'd3, 5'd21, 1'b1, 1'b0);
    wait_results(1);
`ifdef ALU_ISSUE_FWD_EN
    check("t7_fwd_zero", 64'(rq[0].result), 64'd3);
`else
    check("t7_nofwd", 64'(rq[0].result), 64'd10);
`endif
    check("t7_tag", 64'(rq[0].tag), 64'd21);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
